adder_accumulator_ctrl: RTL and testbench

ADDER_ACCUMULATOR_CTRL -- requirements
Module: adder_accumulator_ctrl

---
 rtl/adder_accumulator_ctrl.sv | 128 ++++++++++++
 tb/tb_adder_accumulator_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/adder_accumulator_ctrl.sv
// Accumulator controller wrapped around an external carry-lookahead adder.
// B is loaded from the switches and Acc is cleared while idle. Each Run press
// performs one Acc <= Acc + B, captures the adder carry-out and bumps a
// 4-bit completed-addition counter.
module adder_accumulator_ctrl #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic [WIDTH-1:0] SW,
   input  logic             LoadB,
   input  logic             ClearA,
   input  logic             Run,
   output logic [WIDTH-1:0] Adder_A,
   output logic [WIDTH-1:0] Adder_B,
   input  logic [WIDTH-1:0] Adder_Sum,
   input  logic             Adder_Cout,
   output logic [WIDTH-1:0] Acc_Out,
   output logic [WIDTH-1:0] B_Out,
   output logic             Carry,
   output logic             Busy,
   output logic             Done,
   output logic [3:0]       Add_Count
);

   typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             carry_q, carry_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             run_q;
   logic             run_rise;

   assign run_rise = Run & ~run_q;

   // State register; reset lands in IDLE and aborts any addition in flight.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; a Run edge shared with ClearA or LoadB is dropped.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (run_rise && !ClearA && !LoadB) begin
               state_d = StAdd;
            end
         end
         StAdd: begin
            state_d = StDone;
         end
         StDone: begin
            if (!Run) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // FSM status outputs.
   always_comb begin
      Busy = 1'b0;
      Done = 1'b0;
      unique case (state_q)
         StAdd:   Busy = 1'b1;
         StDone:  Done = 1'b1;
         default: ;
      endcase
   end

   // Datapath next-state: clear/load only in IDLE, capture sum only in ADD.
   always_comb begin
      acc_d   = acc_q;
      b_d     = b_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (ClearA) begin
               acc_d   = '0;
               carry_d = 1'b0;
               cnt_d   = 4'd0;
            end else if (LoadB) begin
               b_d = SW;
            end
         end
         StAdd: begin
            acc_d   = Adder_Sum;
            carry_d = Adder_Cout;
            cnt_d   = cnt_q + 4'd1;
         end
         default: ;
      endcase
   end

   // Datapath registers; run_q resets high so a Run held through reset is not an edge.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         acc_q   <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         cnt_q   <= 4'd0;
         run_q   <= 1'b1;
      end else begin
         acc_q   <= acc_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         run_q   <= Run;
      end
   end

   assign Adder_A   = acc_q;
   assign Adder_B   = b_q;
   assign Acc_Out   = acc_q;
   assign B_Out     = b_q;
   assign Carry     = carry_q;
   assign Add_Count = cnt_q;

endmodule

// File: tb/tb_adder_accumulator_ctrl.sv
// Bench for adder_accumulator_ctrl: directed scenarios plus randomized
// operation sequences checked against an operation-level reference model.
module tb_adder_accumulator_ctrl;

   logic        Clk;
   logic        Reset_n;
   logic [15:0] SW;
   logic        LoadB, ClearA, Run;
   logic [15:0] Adder_A, Adder_B, Adder_Sum;
   logic        Adder_Cout;
   logic [15:0] Acc_Out, B_Out;
   logic        Carry, Busy, Done;
   logic [3:0]  Add_Count;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   int unsigned m_acc, m_b, m_carry, m_cnt;

   adder_accumulator_ctrl #(.WIDTH(16)) dut (
      .Clk        (Clk),
      .Reset_n    (Reset_n),
      .SW         (SW),
      .LoadB      (LoadB),
      .ClearA     (ClearA),
      .Run        (Run),
      .Adder_A    (Adder_A),
      .Adder_B    (Adder_B),
      .Adder_Sum  (Adder_Sum),
      .Adder_Cout (Adder_Cout),
      .Acc_Out    (Acc_Out),
      .B_Out      (B_Out),
      .Carry      (Carry),
      .Busy       (Busy),
      .Done       (Done),
      .Add_Count  (Add_Count)
   );

   // External adder stand-in
   always_comb {Adder_Cout, Adder_Sum} = {1'b0, Adder_A} + {1'b0, Adder_B};

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag, input bit exp_busy, input bit exp_done);
      chk({tag, ".acc"},   {16'h0, Acc_Out},   m_acc & 32'hFFFF);
      chk({tag, ".b"},     {16'h0, B_Out},     m_b & 32'hFFFF);
      chk({tag, ".addA"},  {16'h0, Adder_A},   m_acc & 32'hFFFF);
      chk({tag, ".addB"},  {16'h0, Adder_B},   m_b & 32'hFFFF);
      chk({tag, ".carry"}, {31'h0, Carry},     m_carry);
      chk({tag, ".cnt"},   {28'h0, Add_Count}, m_cnt % 16);
      chk({tag, ".busy"},  {31'h0, Busy},      {31'h0, exp_busy});
      chk({tag, ".done"},  {31'h0, Done},      {31'h0, exp_done});
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic model_reset();
      m_acc = 0; m_b = 0; m_carry = 0; m_cnt = 0;
   endtask

   task automatic model_add();
      int unsigned s;
      s       = m_acc + m_b;
      m_acc   = s % 65536;
      m_carry = s / 65536;
      m_cnt   = (m_cnt + 1) % 16;
   endtask

   task automatic do_clear();
      ClearA = 1'b1;
      step();
      ClearA = 1'b0;
      m_acc = 0; m_carry = 0; m_cnt = 0;
      check_all("clear", 1'b0, 1'b0);
   endtask

   task automatic do_load(input logic [15:0] v);
      LoadB = 1'b1;
      SW    = v;
      step();
      LoadB = 1'b0;
      SW    = $urandom_range(0, 65535);
      m_b   = v;
      check_all("load", 1'b0, 1'b0);
   endtask

   // One Run press; optionally wiggles ClearA/LoadB/SW while ADD/DONE (must be ignored).
   task automatic do_press(input bit noisy);
      Run    = 1'b1;
      ClearA = 1'b0;
      LoadB  = 1'b0;
      step();
      check_all("press.add", 1'b1, 1'b0);
      if (noisy) begin
         ClearA = 1'($urandom_range(0, 1));
         LoadB  = 1'($urandom_range(0, 1));
         SW     = 16'($urandom_range(0, 65535));
      end
      step();
      model_add();
      check_all("press.done", 1'b0, 1'b1);
      step();
      check_all("press.hold", 1'b0, 1'b1);
      Run    = 1'b0;
      ClearA = 1'b0;
      LoadB  = 1'b0;
      step();
      check_all("press.idle", 1'b0, 1'b0);
   endtask

   initial begin
      int busy_cnt, done_cnt;
      Reset_n = 1'b0;
      SW = 16'h0; LoadB = 1'b0; ClearA = 1'b0; Run = 1'b0;
      model_reset();
      #12;
      check_all("reset", 1'b0, 1'b0);
      Reset_n = 1'b1;
      step();
      check_all("post_reset", 1'b0, 1'b0);

      // Three presses of B=1
      do_load(16'h0001);
      for (int i = 0; i < 3; i++) do_press(1'b0);
      chk("three.acc", {16'h0, Acc_Out}, 32'h3);
      chk("three.cnt", {28'h0, Add_Count}, 32'h3);

      // Overflow reported through Carry
      do_clear();
      do_load(16'hFFFF);
      do_press(1'b0);
      chk("ovf1.acc", {16'h0, Acc_Out}, 32'hFFFF);
      chk("ovf1.carry", {31'h0, Carry}, 32'h0);
      do_press(1'b0);
      chk("ovf2.acc", {16'h0, Acc_Out}, 32'hFFFE);
      chk("ovf2.carry", {31'h0, Carry}, 32'h1);

      // Run held 20 cycles: exactly one addition
      do_clear();
      do_load(16'h0007);
      busy_cnt = 0;
      done_cnt = 0;
      Run = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         if (Busy) busy_cnt++;
         if (Done) done_cnt++;
      end
      model_add();
      chk("hold.busy_cycles", busy_cnt, 1);
      chk("hold.done_cycles", done_cnt, 19);
      check_all("hold.end", 1'b0, 1'b1);
      Run = 1'b0;
      step();
      check_all("hold.release", 1'b0, 1'b0);

      // ClearA + LoadB + Run edge together: only the clear happens
      m_b = B_Out === 16'h0007 ? 32'h7 : 32'h7;
      ClearA = 1'b1; LoadB = 1'b1; SW = 16'h1234; Run = 1'b1;
      step();
      m_acc = 0; m_carry = 0; m_cnt = 0;
      check_all("coincide", 1'b0, 1'b0);
      ClearA = 1'b0; LoadB = 1'b0;
      step();
      check_all("coincide.no_retrigger", 1'b0, 1'b0);
      Run = 1'b0;
      step();
      do_load(16'h1234);
      chk("coincide.loadb", {16'h0, B_Out}, 32'h1234);

      // Reset in the middle of ADD
      do_clear();
      do_load(16'h0010);
      do_press(1'b0);
      do_load(16'h0005);
      chk("abort.acc_pre", {16'h0, Acc_Out}, 32'h10);
      Run = 1'b1;
      step();
      check_all("abort.in_add", 1'b1, 1'b0);
      #2 Reset_n = 1'b0;
      #1;
      model_reset();
      check_all("abort.immediate", 1'b0, 1'b0);
      step();
      check_all("abort.held", 1'b0, 1'b0);
      #3 Reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check_all("abort.run_through", 1'b0, 1'b0);
      end
      chk("abort.not_0015", {31'h0, Acc_Out === 16'h0015}, 32'h0);
      Run = 1'b0;
      step();

      // Sixteen additions wrap the counter
      do_clear();
      do_load(16'h0001);
      for (int i = 0; i < 16; i++) do_press(1'b0);
      chk("wrap.acc", {16'h0, Acc_Out}, 32'h10);
      chk("wrap.cnt", {28'h0, Add_Count}, 32'h0);

      // Random operation sequences
      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(0, 5))
            0:       do_clear();
            1, 2:    do_load(16'($urandom_range(0, 65535)));
            default: do_press(1'b1);
         endcase
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule
